// File: rtl/id_pkg.sv
// Shared decode constants and pipeline-register types for the ID stage.
// Used by id_stage and id_regfile.
package id_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src;
      logic    reg_dst;
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    branch;
   } ctrl_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      ctrl_t       ctrl;
   } idex_t;

   localparam ctrl_t CTRL_NOP    = '0;
   localparam idex_t IDEX_BUBBLE = '0;

   function automatic logic [31:0] sign_ext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file, two combinational read ports and one write port; r0 reads 0.
// Optional write-through bypass when ID_RF_BYPASS_EN is defined.
module id_regfile
   import id_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            n_rst_i,
   input  logic [4:0]      raddr_a_i,
   input  logic [4:0]      raddr_b_i,
   output logic [XLEN-1:0] rdata_a_o,
   output logic [XLEN-1:0] rdata_b_o,
   input  logic            we_i,
   input  logic [4:0]      waddr_i,
   input  logic [XLEN-1:0] wdata_i
);

`ifdef ID_RF_BYPASS_EN
   localparam logic BYPASS_EN = 1'b1;
`else
   localparam logic BYPASS_EN = 1'b0;
`endif

   logic [XLEN-1:0] regs_q [32];
   logic            wr_en_s;

   assign wr_en_s = we_i && (waddr_i != 5'd0);

   // Register array storage with asynchronous clear.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en_s) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Read port A; bypass returns the in-flight write data.
   always_comb begin
      rdata_a_o = '0;
      if (raddr_a_i == 5'd0) begin
         rdata_a_o = '0;
      end else if (BYPASS_EN && wr_en_s && (waddr_i == raddr_a_i)) begin
         rdata_a_o = wdata_i;
      end else begin
         rdata_a_o = regs_q[raddr_a_i];
      end
   end

   // Read port B; same structure as port A.
   always_comb begin
      rdata_b_o = '0;
      if (raddr_b_i == 5'd0) begin
         rdata_b_o = '0;
      end else if (BYPASS_EN && wr_en_s && (waddr_i == raddr_b_i)) begin
         rdata_b_o = wdata_i;
      end else begin
         rdata_b_o = regs_q[raddr_b_i];
      end
   end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decode, register read, load-use stall, ID/EX register.
// Define ID_RF_BYPASS_EN to enable register-file write-through.
module id_stage
   import id_pkg::*;
#(
   parameter int unsigned XLEN           = 32,
   parameter bit          NOP_ON_ILLEGAL = 1'b1
) (
   input  logic            clk_i,
   input  logic            n_rst_i,
   input  logic [XLEN-1:0] IFID_pc_i,
   input  logic [31:0]     IFID_ir_i,
   input  logic            MEM_do_branch_i,
   input  logic            WB_we_i,
   input  logic [4:0]      WB_waddr_i,
   input  logic [XLEN-1:0] WB_wdata_i,
   output logic            ID_stall_o,
   output logic [XLEN-1:0] IDEX_pc_o,
   output logic [XLEN-1:0] IDEX_rs_data_o,
   output logic [XLEN-1:0] IDEX_rt_data_o,
   output logic [XLEN-1:0] IDEX_imm_o,
   output logic [4:0]      IDEX_rs_o,
   output logic [4:0]      IDEX_rt_o,
   output logic [4:0]      IDEX_rd_o,
   output logic [2:0]      IDEX_alu_op_o,
   output logic            IDEX_alu_src_o,
   output logic            IDEX_reg_dst_o,
   output logic            IDEX_reg_write_o,
   output logic            IDEX_mem_read_o,
   output logic            IDEX_mem_write_o,
   output logic            IDEX_mem_to_reg_o,
   output logic            IDEX_branch_o
);

   logic [5:0]      opcode_s;
   logic [5:0]      funct_s;
   logic [4:0]      rs_s;
   logic [4:0]      rt_s;
   logic [4:0]      rd_s;
   logic [XLEN-1:0] rs_data_s;
   logic [XLEN-1:0] rt_data_s;
   ctrl_t           ctrl_s;
   logic            illegal_s;
   logic            bubble_s;
   logic            hazard_s;
   idex_t           idex_d;
   idex_t           idex_q;

   assign opcode_s = IFID_ir_i[31:26];
   assign funct_s  = IFID_ir_i[5:0];
   assign rs_s     = IFID_ir_i[25:21];
   assign rt_s     = IFID_ir_i[20:16];
   assign rd_s     = IFID_ir_i[15:11];

   id_regfile #(.XLEN(XLEN)) u_regfile (
      .clk_i     (clk_i),
      .n_rst_i   (n_rst_i),
      .raddr_a_i (rs_s),
      .raddr_b_i (rt_s),
      .rdata_a_o (rs_data_s),
      .rdata_b_o (rt_data_s),
      .we_i      (WB_we_i),
      .waddr_i   (WB_waddr_i),
      .wdata_i   (WB_wdata_i)
   );

   // Control decode; unknown encodings fall back to R-type ADD and are flagged.
   always_comb begin
      ctrl_s    = CTRL_NOP;
      illegal_s = 1'b0;
      case (opcode_s)
         OP_RTYPE: begin
            ctrl_s.reg_write = 1'b1;
            ctrl_s.reg_dst   = 1'b1;
            case (funct_s)
               FN_ADD:  ctrl_s.alu_op = ALU_ADD;
               FN_SUB:  ctrl_s.alu_op = ALU_SUB;
               FN_AND:  ctrl_s.alu_op = ALU_AND;
               FN_OR:   ctrl_s.alu_op = ALU_OR;
               FN_SLT:  ctrl_s.alu_op = ALU_SLT;
               default: begin
                  ctrl_s.alu_op = ALU_ADD;
                  illegal_s     = 1'b1;
               end
            endcase
         end
         OP_ADDI: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.reg_write = 1'b1;
         end
         OP_LW: begin
            ctrl_s.alu_src    = 1'b1;
            ctrl_s.mem_read   = 1'b1;
            ctrl_s.mem_to_reg = 1'b1;
            ctrl_s.reg_write  = 1'b1;
         end
         OP_SW: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl_s.branch = 1'b1;
            ctrl_s.alu_op = ALU_SUB;
         end
         default: begin
            ctrl_s.reg_write = 1'b1;
            ctrl_s.reg_dst   = 1'b1;
            illegal_s        = 1'b1;
         end
      endcase
   end

   assign bubble_s = (IFID_ir_i == 32'd0) || (illegal_s && NOP_ON_ILLEGAL);

   // The rt match is applied to every instruction, I-types included (conservative).
   assign hazard_s = idex_q.ctrl.mem_read && (idex_q.rt != 5'd0) &&
                     ((idex_q.rt == rs_s) || (idex_q.rt == rt_s));

   assign ID_stall_o = hazard_s && !MEM_do_branch_i;

   // ID/EX next state: branch flush beats stall, stall beats normal load.
   always_comb begin
      idex_d = IDEX_BUBBLE;
      if (MEM_do_branch_i) begin
         idex_d = IDEX_BUBBLE;
      end else if (hazard_s) begin
         idex_d = IDEX_BUBBLE;
      end else if (bubble_s) begin
         idex_d = IDEX_BUBBLE;
      end else begin
         idex_d.pc      = IFID_pc_i;
         idex_d.rs_data = rs_data_s;
         idex_d.rt_data = rt_data_s;
         idex_d.imm     = sign_ext16(IFID_ir_i[15:0]);
         idex_d.rs      = rs_s;
         idex_d.rt      = rt_s;
         idex_d.rd      = rd_s;
         idex_d.ctrl    = ctrl_s;
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         idex_q <= IDEX_BUBBLE;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign IDEX_pc_o         = idex_q.pc;
   assign IDEX_rs_data_o    = idex_q.rs_data;
   assign IDEX_rt_data_o    = idex_q.rt_data;
   assign IDEX_imm_o        = idex_q.imm;
   assign IDEX_rs_o         = idex_q.rs;
   assign IDEX_rt_o         = idex_q.rt;
   assign IDEX_rd_o         = idex_q.rd;
   assign IDEX_alu_op_o     = idex_q.ctrl.alu_op;
   assign IDEX_alu_src_o    = idex_q.ctrl.alu_src;
   assign IDEX_reg_dst_o    = idex_q.ctrl.reg_dst;
   assign IDEX_reg_write_o  = idex_q.ctrl.reg_write;
   assign IDEX_mem_read_o   = idex_q.ctrl.mem_read;
   assign IDEX_mem_write_o  = idex_q.ctrl.mem_write;
   assign IDEX_mem_to_reg_o = idex_q.ctrl.mem_to_reg;
   assign IDEX_branch_o     = idex_q.ctrl.branch;

endmodule
